display_scan_ctrl: RTL

Time-multiplexing scan controller for the calculator's 4-digit common-anode 7-segment display. It accepts a packed 4-digit BCD value plus a sign flag through a valid/ready handshake and double-buffers it. It then drives one shared BCD-to-7-segment decoder (codes 0–9 are digits, code 10 is the minus dash) one digit at a time, with active-low anode selects. It sits between the calculator result register and the decoder/pin outputs.

---
 rtl/display_scan_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : 4-digit 7-seg scan controller with a double-buffered valid/ready
//            input. Optional leading-zero blanking via DISPLAY_LZ_BLANK_EN.
// Revision : 1.0
// ============================================================================
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_bcd,
    input  logic        in_neg,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam logic [DIV_W-1:0] C_CNT_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       C_DASH    = 4'd10;

    logic [DIV_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_act_bcd;
    logic             r_act_neg;
    logic [15:0]      r_pend_bcd;
    logic             r_pend_neg;
    logic             r_pend;
    logic [3:0]       r_an;
    logic [3:0]       r_bcd;
    logic             r_frame_start;

    logic             w_tick;
    logic             w_boundary;
    logic             w_xfer;
    logic [15:0]      w_in_clean;
    logic [15:0]      w_act_bcd;
    logic             w_act_neg;
    logic [1:0]       w_nidx;
    logic [3:0]       w_an_nxt;
    logic [3:0]       w_bcd_nxt;
`ifdef DISPLAY_LZ_BLANK_EN
    logic [3:0]       w_blank;
    logic [1:0]       w_dash_slot;
`endif

    assign w_tick     = (r_cnt == C_CNT_MAX);
    assign w_boundary = w_tick && (r_idx == 2'd3);
    assign w_xfer     = in_valid && !r_pend;

    // Out-of-range nibbles are stored as the dash code.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sanitise
        assign w_in_clean[4*gi +: 4] = (in_bcd[4*gi +: 4] > 4'd9) ? C_DASH
                                                                  : in_bcd[4*gi +: 4];
    end

    // Outputs are computed for the slot about to become active, using the
    // buffer that will be active then (pending one if swapped at this edge).
    always_comb begin
        w_act_bcd = (w_boundary && r_pend) ? r_pend_bcd : r_act_bcd;
        w_act_neg = (w_boundary && r_pend) ? r_pend_neg : r_act_neg;
        w_nidx    = r_idx + 2'd1;
        w_an_nxt  = ~(4'b0001 << w_nidx);
        w_bcd_nxt = w_act_bcd[{w_nidx, 2'b00} +: 4];
`ifdef DISPLAY_LZ_BLANK_EN
        w_blank[3] = (w_act_bcd[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (w_act_bcd[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (w_act_bcd[7:4] == 4'd0);
        w_blank[0] = 1'b0;
        if (w_blank[1])      w_dash_slot = 2'd1;
        else if (w_blank[2]) w_dash_slot = 2'd2;
        else                 w_dash_slot = 2'd3;
        if (w_act_neg && (w_nidx == w_dash_slot)) begin
            w_bcd_nxt = C_DASH;
        end else if (w_blank[w_nidx]) begin
            w_an_nxt  = 4'b1111;
            w_bcd_nxt = 4'd0;
        end
`else
        if (w_act_neg && (w_nidx == 2'd3)) begin
            w_bcd_nxt = C_DASH;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_idx         <= 2'd3;
            r_act_bcd     <= 16'd0;
            r_act_neg     <= 1'b0;
            r_pend_bcd    <= 16'd0;
            r_pend_neg    <= 1'b0;
            r_pend        <= 1'b0;
            r_an          <= 4'b1111;
            r_bcd         <= 4'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= w_nidx;
                r_an  <= w_an_nxt;
                r_bcd <= w_bcd_nxt;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
            if (w_boundary && r_pend) begin
                r_act_bcd <= r_pend_bcd;
                r_act_neg <= r_pend_neg;
            end
            // A transfer needs pend=0, so it can never collide with a swap.
            if (w_xfer) begin
                r_pend_bcd <= w_in_clean;
                r_pend_neg <= in_neg;
                r_pend     <= 1'b1;
            end else if (w_boundary) begin
                r_pend     <= 1'b0;
            end
        end
    end

    assign in_ready    = ~r_pend;
    assign an          = r_an;
    assign bcd         = r_bcd;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
